// File: rtl/reg_load_arbiter.sv
// Round-robin arbiter that sequences one-cycle loads into a shared
// DFlop register bank and counts the loads it completes.
module reg_load_arbiter #(
   parameter int N = 4,
   parameter int W = 8
) (
   input  logic           clk,
   input  logic           arst,
   input  logic [N-1:0]   req,
   input  logic [N*W-1:0] wdata,
   output logic [N-1:0]   grant,
   output logic           eload,
   output logic [W-1:0]   dload,
   output logic [N-1:0]   ack,
   output logic           busy,
   output logic [7:0]     load_cnt
);
   localparam int IW = $clog2(N);

   typedef enum logic [1:0] {IDLE, GRANT, LOAD, ACK} state_t;

   state_t        state, state_n;
   logic [IW-1:0] last, last_n;
   logic [IW-1:0] win, win_n;
   logic [IW-1:0] pick;
   logic [IW:0]   idx;
   logic          found;
   logic [N-1:0]  grant_n, ack_n;
   logic          eload_n, busy_n;
   logic [W-1:0]  dload_n;
   logic [7:0]    cnt_n;

   function automatic logic [N-1:0] onehot(input logic [IW-1:0] i);
      onehot    = '0;
      onehot[i] = 1'b1;
   endfunction

   // Scan from last+1 with an explicit modulo-N wrap.
   always_comb begin
      pick  = '0;
      found = 1'b0;
      idx   = '0;
      for (int k = 0; k < N; k++) begin
         idx = (IW+1)'(last) + (IW+1)'(k + 1);
         if (idx >= (IW+1)'(N))
            idx = idx - (IW+1)'(N);
         if (!found && req[idx[IW-1:0]]) begin
            found = 1'b1;
            pick  = idx[IW-1:0];
         end
      end
   end

   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         state    <= IDLE;
         grant    <= '0;
         eload    <= 1'b0;
         dload    <= '0;
         ack      <= '0;
         busy     <= 1'b0;
         load_cnt <= '0;
         last     <= IW'(N - 1);
         win      <= '0;
      end else begin
         state    <= state_n;
         grant    <= grant_n;
         eload    <= eload_n;
         dload    <= dload_n;
         ack      <= ack_n;
         busy     <= busy_n;
         load_cnt <= cnt_n;
         last     <= last_n;
         win      <= win_n;
      end
   end

   always_comb begin
      state_n = state;
      unique case (state)
         IDLE:    if (found) state_n = GRANT;
         GRANT:   state_n = req[win] ? LOAD : IDLE;
         LOAD:    state_n = ACK;
         ACK:     state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   // Next values for the registered outputs.
   always_comb begin
      grant_n = grant;
      eload_n = 1'b0;
      dload_n = dload;
      ack_n   = '0;
      cnt_n   = load_cnt;
      last_n  = last;
      win_n   = win;
      busy_n  = (state_n != IDLE);
      unique case (state)
         IDLE: begin
            if (found) begin
               win_n   = pick;
               grant_n = onehot(pick);
            end
         end
         GRANT: begin
            if (req[win]) begin
               dload_n = wdata[int'(win)*W +: W];
               eload_n = 1'b1;
            end else begin
               grant_n = '0;
            end
         end
         LOAD: begin
            ack_n  = onehot(win);
            cnt_n  = load_cnt + 8'd1;
            last_n = win;
         end
         ACK:     grant_n = '0;
         default: grant_n = '0;
      endcase
   end
endmodule

// File: doc/reg_load_arbiter.md
# reg_load_arbiter

Round-robin arbiter and load sequencer for a shared W-bit register bank built from DFlop cells, i.e. data-flop cells with async reset, a load enable and a load-data input. Up to N requesters, such as sensor and control units of the smart-house controller, post write requests. The block grants one requester at a time, stages its data and drives the bank's common load enable and load data for exactly one cycle. It then acknowledges the winner and keeps a count of completed loads.

## Interface
Parameters:
- N, 4: number of requesters (2..8)
- W, 8: register bank width

Ports:
- clk  in  1  clock, all state updates on posedge
- arst  in  1  reset, asynchronous, active-high; clears all state and outputs immediately
- req  in  N  per-requester write request, level; held high until own ack
- wdata  in  N*W  requester data, slice i = wdata[i*W +: W]; must be stable while req[i] high
- grant  out  N  one-hot current grant, all-zero when idle
- eload  out  1  load enable to every bank cell, one-cycle pulse
- dload  out  W  load data to every bank cell
- ack  out  N  one-hot completion pulse to the winner, one cycle
- busy  out  1  high in any state other than IDLE
- load_cnt  out  8  completed-load counter, wraps 255→0

## Operation
- States: IDLE, GRANT, LOAD, ACK. Encoding is free. All outputs are registered.
- Every output resets to 0, state resets to IDLE and the round-robin pointer last resets to N-1, so requester 0 has first priority after reset.
- **IDLE**
  - If req≠0: winner = first set bit scanning from (last+1) mod N upward with wrap. grant ← onehot(winner), state → GRANT.
  - If req=0: stay in IDLE, outputs stay 0.
- **GRANT**
  - If req[winner]=1: dload ← wdata slice of winner, eload ← 1, state → LOAD.
  - If req[winner]=0 (abort): grant ← 0, state → IDLE. No eload, no ack, last unchanged, load_cnt unchanged.
- **LOAD**
  - The bank captures dload at this edge.
  - eload ← 0, ack ← onehot(winner), load_cnt ← load_cnt+1, last ← winner, state → ACK.
  - req is ignored from LOAD onward; a load that has started always completes.
- **ACK**
  - ack ← 0, grant ← 0, state → IDLE.
  - dload holds its last value until the next load and is never cleared except by reset.
- Requests arriving during GRANT, LOAD or ACK wait. Arbitration happens only in IDLE.
- Simultaneous requests: exactly one grant, chosen by the rotating scan. No requester is starved; with all N requesting continuously, each is served once per N loads.
- Requester protocol: drop req[i] within one cycle of seeing ack[i]. A req still high when IDLE samples it counts as a new request.
- When N does not divide 2^k, pointer wrap uses explicit modulo N and never indexes past N-1.

## Timing
- Request sampled high at edge E1 (state IDLE) gives:
  - grant valid after E1
  - eload=1 and dload valid after E2
  - bank loaded at E3; ack and load_cnt update after E3
  - back in IDLE after E4
- Latency is 3 edges from the sampling edge to bank capture. Minimum spacing between loads is 4 cycles.
- eload is high for exactly one cycle per load and only in LOAD. grant is asserted continuously through the grant–load–ack sequence and is never all-zero between GRANT entry and ACK exit unless aborted.
- Reset asserted mid-sequence, including the cycle eload is high:
  - eload, grant, ack, busy and load_cnt go to 0 asynchronously; no ack is issued.
  - After deassertion the next arbitration starts from requester 0.

## Test plan
- Single request: N=4, W=8. req=0001 with wdata[7:0]=0xA5, sampled at E1 → grant=0001 after E1; eload=1, dload=0xA5 after E2; ack=0001, load_cnt=1 after E3; busy=0 after E4.
- Fairness: req=1111 held and each requester re-raises req after its ack → grant order 0,1,2,3,0 and load_cnt=5 after 5 loads.
- Priority rotation: after a load for requester 2, req=0101 → requester 0 is granted next (scan from 3 wraps to 0).
- Abort: requester 1 granted, req[1] dropped before the GRANT edge → no eload, no ack, grant=0, load_cnt unchanged, last unchanged. Re-raising req[1] makes it win again.
- Async reset: arst pulsed while eload=1 → eload, grant, ack and busy are 0 within the same cycle; load_cnt=0; after release, req=1000 gives grant=1000.
- Counter wrap: 256 consecutive loads → load_cnt returns to 0, and each load produces exactly one eload pulse.
